// File: rtl/ysyx_22040210_div_ctrl.sv
// ============================================================================
// Module   : ysyx_22040210_div_ctrl
// Brief    : Upstream controller for the unsigned pipelined divider core.
//            Normalises RV64M DIV/DIVU/REM/REMU(W) operands, resolves
//            divide-by-zero and signed overflow locally, issues everything
//            else to the core and re-signs the returned quotient/remainder.
//            Optional macro YSYX_22040210_DIV_BYPASS_EN adds |b|==1 and
//            |a|<|b| short-cuts that skip the core.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ysyx_22040210_div_ctrl #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic             req_signed_i,
    input  logic             req_rem_i,
    input  logic             req_word_i,
    input  logic [WIDTH-1:0] req_src1_i,
    input  logic [WIDTH-1:0] req_src2_i,
    input  logic             flush_i,
    output logic             res_valid_o,
    input  logic             res_ready_i,
    output logic [WIDTH-1:0] res_data_o,
    output logic             core_valid_o,
    output logic [WIDTH-1:0] core_dividend_o,
    output logic [WIDTH-1:0] core_divisor_o,
    output logic             core_ack_o,
    input  logic             core_qrvalid_i,
    input  logic [WIDTH-1:0] core_quotient_i,
    input  logic [WIDTH-1:0] core_remainder_i
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SPECIAL = 3'd1,
        S_ISSUE   = 3'd2,
        S_WAIT    = 3'd3,
        S_DONE    = 3'd4,
        S_DRAIN   = 3'd5
    } state_t;

    state_t           r_state;
    logic             r_rem;
    logic             r_word;
    logic             r_neg_q;
    logic             r_neg_r;
    logic [WIDTH-1:0] r_dividend;
    logic [WIDTH-1:0] r_divisor;
    logic [WIDTH-1:0] r_result;
    logic             r_res_valid;

    // W results are always the sign-extension of bit 31, signed or not
    function automatic logic [WIDTH-1:0] f_fmt(input logic word, input logic [WIDTH-1:0] v);
        return word ? {{(WIDTH-32){v[31]}}, v[31:0]} : v;
    endfunction

    // ------------------------------------------------------------------
    // Operand preparation on the live request fields
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;
    logic [WIDTH-1:0] w_abs_a;
    logic [WIDTH-1:0] w_abs_b;
    logic [WIDTH-1:0] w_min_neg;
    logic             w_neg_q;
    logic             w_neg_r;
    logic             w_div_zero;
    logic             w_ovf;
    logic             w_special;
    logic [WIDTH-1:0] w_spec_q;
    logic [WIDTH-1:0] w_spec_r;
    logic [WIDTH-1:0] w_core_q;
    logic [WIDTH-1:0] w_core_r;

    assign w_a = req_word_i ? {{(WIDTH-32){req_signed_i & req_src1_i[31]}}, req_src1_i[31:0]}
                            : req_src1_i;
    assign w_b = req_word_i ? {{(WIDTH-32){req_signed_i & req_src2_i[31]}}, req_src2_i[31:0]}
                            : req_src2_i;

    // After extension the top bit is the operand sign at either op width
    assign w_neg_q = req_signed_i & (w_a[WIDTH-1] ^ w_b[WIDTH-1]);
    assign w_neg_r = req_signed_i & w_a[WIDTH-1];

    assign w_abs_a = (req_signed_i & w_a[WIDTH-1]) ? -w_a : w_a;
    assign w_abs_b = (req_signed_i & w_b[WIDTH-1]) ? -w_b : w_b;

    // Most-negative value at op width, as seen after sign extension
    assign w_min_neg = req_word_i ? {{(WIDTH-31){1'b1}}, 31'b0} : {1'b1, {(WIDTH-1){1'b0}}};

    assign w_div_zero = (w_b == '0);
    assign w_ovf      = req_signed_i & (w_a == w_min_neg) & (&w_b);

    // Pick the locally resolved quotient/remainder; overflow wins over bypass
    always_comb begin
        w_special = 1'b0;
        w_spec_q  = '0;
        w_spec_r  = '0;
        if (w_div_zero) begin
            w_special = 1'b1;
            w_spec_q  = '1;
            w_spec_r  = w_a;
        end else if (w_ovf) begin
            w_special = 1'b1;
            w_spec_q  = w_a;
            w_spec_r  = '0;
        end
`ifdef YSYX_22040210_DIV_BYPASS_EN
        else if (w_abs_b == WIDTH'(1)) begin
            w_special = 1'b1;
            w_spec_q  = w_neg_q ? -w_abs_a : w_abs_a;
            w_spec_r  = '0;
        end else if (w_abs_a < w_abs_b) begin
            w_special = 1'b1;
            w_spec_q  = '0;
            w_spec_r  = w_neg_r ? -w_abs_a : w_abs_a;
        end
`else
        else begin
            w_special = 1'b0;
        end
`endif
    end

    // Re-sign the unsigned core results with the latched sign flags
    assign w_core_q = r_neg_q ? -core_quotient_i  : core_quotient_i;
    assign w_core_r = r_neg_r ? -core_remainder_i : core_remainder_i;

    // ------------------------------------------------------------------
    // Control FSM with registered result/operand outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_rem       <= 1'b0;
            r_word      <= 1'b0;
            r_neg_q     <= 1'b0;
            r_neg_r     <= 1'b0;
            r_dividend  <= '0;
            r_divisor   <= '0;
            r_result    <= '0;
            r_res_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid_i && !flush_i) begin
                        r_rem      <= req_rem_i;
                        r_word     <= req_word_i;
                        r_neg_q    <= w_neg_q;
                        r_neg_r    <= w_neg_r;
                        r_dividend <= w_abs_a;
                        r_divisor  <= w_abs_b;
                        if (w_special) begin
                            r_result    <= f_fmt(req_word_i, req_rem_i ? w_spec_r : w_spec_q);
                            r_res_valid <= 1'b1;
                            r_state     <= S_SPECIAL;
                        end else begin
                            r_state <= S_ISSUE;
                        end
                    end
                end
                S_SPECIAL, S_DONE: begin
                    if (flush_i || res_ready_i) begin
                        r_res_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                S_ISSUE: begin
                    r_state <= flush_i ? S_IDLE : S_WAIT;
                end
                S_WAIT: begin
                    if (core_qrvalid_i) begin
                        // Core result acknowledged this cycle; a coincident flush drops it
                        if (flush_i) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_result    <= f_fmt(r_word, r_rem ? w_core_r : w_core_q);
                            r_res_valid <= 1'b1;
                            r_state     <= S_DONE;
                        end
                    end else if (flush_i) begin
                        r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (core_qrvalid_i) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_res_valid <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready_o     = (r_state == S_IDLE);
    assign core_valid_o    = (r_state == S_ISSUE) & ~flush_i;
    assign core_ack_o      = ((r_state == S_WAIT) | (r_state == S_DRAIN)) & core_qrvalid_i;
    assign core_dividend_o = r_dividend;
    assign core_divisor_o  = r_divisor;
    assign res_valid_o     = r_res_valid;
    assign res_data_o      = r_result;

endmodule

`default_nettype wire

// File: doc/ysyx_22040210_div_ctrl.md
Name: ysyx_22040210_div_ctrl

Overview:
- Upstream controller for the unsigned pipelined divider core in the MDU.
- Accepts RISC-V M-extension divide requests from EXU: DIV/DIVU/REM/REMU and the W forms.
- Normalises operands: word extraction, sign extension, absolute value.
- Handles divide-by-zero and signed overflow itself, without the core; issues all other requests to the core and re-signs its quotient/remainder into one 64-bit writeback result.

Parameters:
- WIDTH, 64, datapath width; must match the divider core WIDTH.

Ports:
- clk  in  1  clock
- rst  in  1  reset: synchronous, active-high
- req_valid_i  in  1  EXU request valid
- req_ready_o  out  1  controller can accept a request
- req_signed_i  in  1  1 = DIV/REM(W), 0 = unsigned
- req_rem_i  in  1  1 = return remainder, 0 = quotient
- req_word_i  in  1  1 = W variant (32-bit op, sign-extended result)
- req_src1_i  in  WIDTH  dividend
- req_src2_i  in  WIDTH  divisor
- flush_i  in  1  pipeline flush; discard in-flight request
- res_valid_o  out  1  result valid
- res_ready_i  in  1  WBU accepts result
- res_data_o  out  WIDTH  final result
- core_valid_o  out  1  one-cycle issue pulse to core (drives div_datavalid_i)
- core_dividend_o  out  WIDTH  unsigned dividend to core
- core_divisor_o  out  WIDTH  unsigned nonzero divisor to core
- core_ack_o  out  1  clears core output regs (drives div_ready)
- core_qrvalid_i  in  1  core result valid
- core_quotient_i  in  WIDTH  unsigned quotient
- core_remainder_i  in  WIDTH  unsigned remainder

Behaviour:
- States: IDLE, SPECIAL, ISSUE, WAIT, DONE, DRAIN.
- Reset: all outputs 0 except req_ready_o; state IDLE; internal operand/result registers 0.
- req_ready_o = (state==IDLE). A request is accepted on the edge where req_valid_i & req_ready_o. All request fields are latched then; later input changes are ignored.
- Operand prep at accept:
  - Word ops: a=src1[31:0], b=src2[31:0]; sign-extended to WIDTH if signed, zero-extended otherwise.
  - neg_q = signed & (a_msb ^ b_msb); neg_r = signed & a_msb.
  - Magnitudes |a|, |b| are taken only when signed.
- Special cases (IDLE→SPECIAL):
  - b==0: quotient = all-ones, remainder = a.
  - Signed overflow (a = most-negative at op width, b = -1): quotient = a, remainder = 0.
- Otherwise IDLE→ISSUE.
- ISSUE: core_valid_o=1 for exactly one cycle with the magnitudes on core_dividend_o/core_divisor_o; →WAIT.
- WAIT: on core_qrvalid_i, capture core outputs, core_ack_o=1 that same cycle (combinational), →DONE.
  - Final quotient = neg_q ? -q : q. Final remainder = neg_r ? -r : r.
- SPECIAL/DONE:
  - res_valid_o=1.
  - res_data_o = selected quotient/remainder; for word ops, sign-extension of bit 31 of the 32-bit result. This applies to DIVUW/REMUW too.
  - Held stable until res_ready_i, then →IDLE. A new request is accepted no earlier than the cycle after the handshake.
- Latency, accept to res_valid_o:
  - Special: 1 cycle.
  - Normal: core latency + 3 cycles (ISSUE, capture in WAIT, DONE register).
- flush_i (highest priority after rst):
  - IDLE/SPECIAL/ISSUE/DONE → IDLE. ISSUE pulse is suppressed if flush_i is in the same cycle; res_valid_o drops next cycle.
  - WAIT → DRAIN. DRAIN keeps req_ready_o=0 until core_qrvalid_i, pulses core_ack_o, discards the result, →IDLE.
  - flush_i in DRAIN is ignored.
- flush_i with req_valid_i in IDLE: no accept.
- rst mid-operation: FSM→IDLE immediately. The core is reset on the same rst.

Optional Feature:
- Macro: YSYX_22040210_DIV_BYPASS_EN.
- Defined: additional SPECIAL-path cases with 1-cycle latency and no core issue:
  - |b|==1: q = |a|, r = 0.
  - |a| < |b|: q = 0, r = |a|.
  - Both then re-signed as normal.
- Undefined: only divide-by-zero and signed overflow bypass the core. Results are bit-identical either way.

Test Plan:
- DIV src1=-7, src2=2 → after core returns, res_data_o=-3 (0xFFFF_FFFF_FFFF_FFFD); REM same operands → -1.
- DIVU src2=0, src1=0x1234 → res_valid_o one cycle after accept, res_data_o=0xFFFF_FFFF_FFFF_FFFF, core_valid_o never asserted; REMU → 0x1234.
- DIV src1=0x8000_0000_0000_0000, src2=-1 → 0x8000_0000_0000_0000 in 1 cycle; DIVW src1=0x8000_0000, src2=0xFFFF_FFFF → 0xFFFF_FFFF_8000_0000; REMW → 0.
- DIVUW src1=0xFFFF_FFFF_FFFF_FFFE, src2=1 → core sees 0xFFFF_FFFE / 1; res_data_o=0xFFFF_FFFF_FFFF_FFFE (bit-31 extension).
- Hold res_ready_i=0 for 5 cycles in DONE → res_data_o stable, req_ready_o=0; handshake → IDLE next cycle, back-to-back second request accepted.
- flush_i two cycles after ISSUE → DRAIN, no res_valid_o, core_ack_o pulses once on core_qrvalid_i, then req_ready_o=1 and the next REM computes correctly.
